// File: rtl/branch_target_buffer.sv
`default_nettype none
// ============================================================================
// Module   : branch_target_buffer
// Brief    : Direct-mapped BTB with 2-bit saturating counters and branch
//            statistics. Lookups are combinational; training happens at posedge.
// Revision : 1.0 - initial release
// ============================================================================
module branch_target_buffer #(
    parameter  int ENTRIES = 16,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    output logic        pred_hit,
    input  logic        flush,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_mispredict,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispredict_cnt
);

    localparam int        c_TAG_W    = 30 - IDX_W;
    localparam logic [1:0] c_CNT_SNT = 2'b00;
    localparam logic [1:0] c_CNT_WNT = 2'b01;
    localparam logic [1:0] c_CNT_WT  = 2'b10;
    localparam logic [1:0] c_CNT_ST  = 2'b11;

    logic                 r_valid  [ENTRIES];
    logic [c_TAG_W-1:0]   r_tag    [ENTRIES];
    logic [31:0]          r_target [ENTRIES];
    logic [1:0]           r_cnt    [ENTRIES];

    logic [IDX_W-1:0]     w_idx;
    logic [c_TAG_W-1:0]   w_tag;
    logic                 w_hit;
    logic [IDX_W-1:0]     w_uidx;
    logic [c_TAG_W-1:0]   w_utag;
    logic                 w_uhit;
    logic                 w_unused;

    // Instructions are word aligned, so the byte offset carries no information.
    assign w_unused = ^{if_pc[1:0], upd_pc[1:0]};

    assign w_idx  = if_pc[IDX_W+1:2];
    assign w_tag  = if_pc[31:IDX_W+2];
    assign w_uidx = upd_pc[IDX_W+1:2];
    assign w_utag = upd_pc[31:IDX_W+2];

    assign w_hit  = r_valid[w_idx]  && (r_tag[w_idx]  == w_tag);
    assign w_uhit = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);

    assign pred_hit    = w_hit;
    assign pred_taken  = w_hit && r_cnt[w_idx][1];
    assign pred_target = pred_taken ? r_target[w_idx] : (if_pc + 32'd4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_cnt[i]    <= c_CNT_WNT;
            end
        end else if (flush) begin
            // Flush beats any same-cycle training; only valid bits matter afterwards.
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
            end
        end else if (upd_valid) begin
            if (w_uhit) begin
                if (upd_taken) begin
                    r_target[w_uidx] <= upd_target;
                    if (r_cnt[w_uidx] != c_CNT_ST) begin
                        r_cnt[w_uidx] <= r_cnt[w_uidx] + 2'd1;
                    end
                end else if (r_cnt[w_uidx] != c_CNT_SNT) begin
                    r_cnt[w_uidx] <= r_cnt[w_uidx] - 2'd1;
                end
            end else if (upd_taken) begin
                r_valid[w_uidx]  <= 1'b1;
                r_tag[w_uidx]    <= w_utag;
                r_target[w_uidx] <= upd_target;
                r_cnt[w_uidx]    <= c_CNT_WT;
            end
        end
    end

    // Statistics are independent of flush and wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else if (upd_valid) begin
            branch_cnt <= branch_cnt + 32'd1;
            if (upd_mispredict) begin
                mispredict_cnt <= mispredict_cnt + 32'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_target_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_target_buffer
// Brief    : Directed scoreboard bench for branch_target_buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        pred_hit;
    logic        flush;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        string       name;
        logic        hit;
        logic        taken;
        logic [31:0] tgt;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t exp_q[$];

    branch_target_buffer #(.ENTRIES(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .pred_hit       (pred_hit),
        .flush          (flush),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_mispredict (upd_mispredict),
        .branch_cnt     (branch_cnt),
        .mispredict_cnt (mispredict_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: one expectation is consumed per falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            tests_run++;
            if (pred_hit !== e.hit || pred_taken !== e.taken || pred_target !== e.tgt ||
                branch_cnt !== e.bc || mispredict_cnt !== e.mc) begin
                tests_failed++;
                $display("FAIL %s: got hit=%0b taken=%0b tgt=%h bc=%0d mc=%0d, want hit=%0b taken=%0b tgt=%h bc=%0d mc=%0d",
                         e.name, pred_hit, pred_taken, pred_target, branch_cnt, mispredict_cnt,
                         e.hit, e.taken, e.tgt, e.bc, e.mc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                         input logic ut, input logic [31:0] utgt, input logic um,
                         input logic fl);
        if_pc          = pc;
        upd_valid      = uv;
        upd_pc         = upc;
        upd_taken      = ut;
        upd_target     = utgt;
        upd_mispredict = um;
        flush          = fl;
    endtask

    task automatic idle(input logic [31:0] pc);
        drive(pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic expect_out(input string name, input logic hit, input logic taken,
                              input logic [31:0] tgt, input logic [31:0] bc,
                              input logic [31:0] mc);
        exp_t e;
        e.name = name; e.hit = hit; e.taken = taken; e.tgt = tgt; e.bc = bc; e.mc = mc;
        exp_q.push_back(e);
    endtask

    initial begin
        rst = 1'b1;
        idle(32'h100);
        #1;
        expect_out("reset", 0, 0, 32'h104, 0, 0);
        tick();
        tick();
        rst = 1'b0;

        // Allocation on a taken miss; lookup in the same cycle still misses.
        drive(32'h100, 1, 32'h100, 1, 32'h200, 0, 0);
        expect_out("alloc_same_cycle", 0, 0, 32'h104, 0, 0);
        tick();
        idle(32'h100);
        expect_out("alloc_hit", 1, 1, 32'h200, 1, 0);
        tick();

        // Walk the counter down: 10 -> 01 -> 00.
        drive(32'h100, 1, 32'h100, 0, 32'h0, 1, 0);
        tick();
        drive(32'h100, 1, 32'h100, 0, 32'h0, 0, 0);
        expect_out("wnt", 1, 0, 32'h104, 2, 1);
        tick();
        idle(32'h100);
        expect_out("snt", 1, 0, 32'h104, 3, 1);
        tick();

        // Four taken updates saturate at 11.
        drive(32'h100, 1, 32'h100, 1, 32'h200, 1, 0); tick();
        drive(32'h100, 1, 32'h100, 1, 32'h200, 1, 0); tick();
        drive(32'h100, 1, 32'h100, 1, 32'h200, 0, 0); tick();
        drive(32'h100, 1, 32'h100, 1, 32'h200, 0, 0); tick();
        idle(32'h100);
        expect_out("st_sat", 1, 1, 32'h200, 7, 3);
        tick();
        drive(32'h100, 1, 32'h100, 0, 32'h0, 1, 0); tick();
        idle(32'h100);
        expect_out("wt_after_nt", 1, 1, 32'h200, 8, 4);
        tick();

        // Aliasing entry at the same index with a different tag.
        drive(32'h140, 1, 32'h140, 0, 32'h0, 0, 0);
        expect_out("alias_miss", 0, 0, 32'h144, 8, 4);
        tick();
        idle(32'h100);
        expect_out("nt_miss_noalloc", 1, 1, 32'h200, 9, 4);
        tick();
        drive(32'h100, 1, 32'h140, 1, 32'h300, 1, 0); tick();
        idle(32'h100);
        expect_out("evicted", 0, 0, 32'h104, 10, 5);
        tick();
        idle(32'h140);
        expect_out("new_tag", 1, 1, 32'h300, 10, 5);
        tick();
        idle(32'h143);
        expect_out("byte_offset_ignored", 1, 1, 32'h300, 10, 5);
        tick();

        // No bypass: same-cycle lookup sees old target.
        drive(32'h140, 1, 32'h140, 1, 32'h400, 0, 0);
        expect_out("same_cycle_old", 1, 1, 32'h300, 10, 5);
        tick();
        idle(32'h140);
        expect_out("same_cycle_new", 1, 1, 32'h400, 11, 5);
        tick();

        // Flush wins over a same-cycle update but statistics still count it.
        drive(32'h140, 1, 32'h140, 1, 32'h500, 1, 1); tick();
        idle(32'h140);
        expect_out("flush_clear", 0, 0, 32'h144, 12, 6);
        tick();
        idle(32'h100);
        expect_out("flush_clear2", 0, 0, 32'h104, 12, 6);
        tick();

        // Repopulate, then assert rst between edges with an update in flight.
        drive(32'h100, 1, 32'h100, 1, 32'h600, 0, 0); tick();
        idle(32'h100);
        expect_out("repop", 1, 1, 32'h600, 13, 6);
        tick();
        drive(32'h100, 1, 32'h208, 1, 32'h700, 1, 0);
        #1;
        rst = 1'b1;
        #1;
        expect_out("async_rst", 0, 0, 32'h104, 0, 0);
        @(negedge clk);
        #1;
        idle(32'h100);
        rst = 1'b0;
        tick();
        drive(32'h208, 1, 32'h208, 1, 32'h700, 0, 0);
        expect_out("no_ghost", 0, 0, 32'h20c, 0, 0);
        tick();
        idle(32'h100);
        expect_out("no_ghost2", 0, 0, 32'h104, 1, 0);
        tick();
        idle(32'h208);
        expect_out("post_rst_upd", 1, 1, 32'h700, 1, 0);
        tick();

        tick();
        tick();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
